sort4_sequencer: RTL and testbench

Sequencing controller that owns a single 4-bit magnitude comparator and time-shares it to bubble-sort a frame of N unsigned values into ascending order. The block accepts a frame over a valid/ready input stream and performs one compare and conditional swap per cycle. It then streams the sorted frame out over a valid/ready output stream. It sits between the lab's data source (switch/LFSR feeder) and the display/output logic.

---
 rtl/sort_pkg.sv | 10 +
 rtl/mag_cmp4.sv | 12 +
 rtl/sort4_sequencer.sv | 95 +++++++++
 tb/tb_sort4_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and default frame parameters for the sort sequencer
package sort_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;
  localparam int N_DEF = 8;
  localparam int W_DEF = 4;
endpackage

// File: rtl/mag_cmp4.sv
// mag_cmp4: combinational 4-bit unsigned magnitude comparator
module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

// File: rtl/sort4_sequencer.sv
// sort4_sequencer: loads a frame, bubble-sorts it through one shared comparator, streams it out
module sort4_sequencer
  import sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [7:0]   swap_cnt,
  output logic         done
);
  localparam int PW = $clog2(N);
  state_t         state;
  logic [W-1:0]   buf_q [N];
  logic [PW-1:0]  wr_ptr, rd_ptr, idx, idx_n, pass;
  logic           swapped;
  logic [W-1:0]   cmp_a, cmp_b;
  logic           gt, lt, eq;
  assign idx_n     = idx + 1'b1;
  assign cmp_a     = buf_q[idx];
  assign cmp_b     = buf_q[idx_n];
  assign in_ready  = state == LOAD;
  assign busy      = state == SORT;
  assign out_valid = state == DRAIN;
  assign out_data  = (state == DRAIN) ? buf_q[rd_ptr] : '0;
  assign done      = (state == DRAIN) && out_ready && (rd_ptr == PW'(N - 1));
  mag_cmp4 u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );
  assert property (@(posedge Clk) disable iff (Reset) $onehot({gt, lt, eq}));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          buf_q[wr_ptr] <= in_data;
          wr_ptr        <= wr_ptr + 1'b1;
          if (wr_ptr == PW'(N - 1)) begin
            state    <= SORT;
            wr_ptr   <= '0;
            idx      <= '0;
            pass     <= '0;
            swapped  <= 1'b0;
            swap_cnt <= '0;
          end
        end
        SORT: begin
          if (gt) begin
            buf_q[idx]   <= cmp_b;
            buf_q[idx_n] <= cmp_a;
            swap_cnt     <= (swap_cnt == 8'hff) ? swap_cnt : swap_cnt + 8'd1;
          end
          if (idx == PW'(N - 2)) begin
            // a clean pass, or N-1 passes, guarantees the frame is ordered
            if (!(swapped || gt) || pass == PW'(N - 2)) state <= DRAIN;
            else pass <= pass + 1'b1;
            swapped <= 1'b0;
            idx     <= '0;
          end else begin
            idx     <= idx_n;
            swapped <= swapped | gt;
          end
        end
        DRAIN: if (out_ready) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (rd_ptr == PW'(N - 1)) begin
            state  <= LOAD;
            rd_ptr <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort4_sequencer.sv
// tb_sort4_sequencer: randomized scoreboard bench against a stable-sort reference model
module tb_sort4_sequencer;
  localparam int N = 8;
  localparam int W = 4;
  typedef struct {
    logic [3:0] d;
    bit         last;
    bit         first;
    int         swaps;
    int         cycles;
  } exp_t;
  logic         Clk = 0;
  logic         Reset = 1;
  logic         in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1;
  logic         busy;
  logic [7:0]   swap_cnt;
  logic         done;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ready_mode = 0;
  bit   chk_eq = 0;
  int   run = 0;
  sort4_sequencer #(.N(N), .W(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .swap_cnt  (swap_cnt),
    .done      (done)
  );
  always #5 Clk = ~Clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: stable sort, inversion count, and pass count from the largest left-displacement
  task automatic model(input logic [3:0] v [N], output logic [3:0] s [N], output int inv, output int cycles);
    int k = 0;
    s = v;
    for (int i = 1; i < N; i++) begin
      logic [3:0] key = s[i];
      int j = i - 1;
      while (j >= 0 && s[j] > key) begin
        s[j + 1] = s[j];
        j--;
      end
      s[j + 1] = key;
    end
    inv = 0;
    for (int j = 0; j < N; j++) begin
      int c = 0;
      for (int i = 0; i < j; i++) if (v[i] > v[j]) c++;
      inv += c;
      if (c > k) k = c;
    end
    cycles = ((k + 1 < N - 1) ? k + 1 : N - 1) * (N - 1);
  endtask
  task automatic send(input logic [3:0] v);
    int t = 0;
    in_valid = 1;
    in_data  = v;
    @(negedge Clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge Clk);
    end
    if (!in_ready) cmp("send_timeout", 0, 1);
    @(posedge Clk);
    #1;
    in_valid = 0;
  endtask
  task automatic frame(input logic [3:0] v [N], input int gap_after, input bit push);
    logic [3:0] s [N];
    int inv, cyc, t;
    model(v, s, inv, cyc);
    if (push)
      for (int i = 0; i < N; i++)
        sb.push_back('{d: s[i], last: i == N - 1, first: i == 0, swaps: (inv > 255) ? 255 : inv, cycles: cyc});
    for (int i = 0; i < N; i++) begin
      send(v[i]);
      cmp("busy_after_accept", busy, i == N - 1);
      if (i == gap_after)
        repeat (3) begin
          @(posedge Clk);
          #1;
          cmp("gap_in_ready", in_ready, 1);
          cmp("gap_busy", busy, 0);
        end
    end
    if (push) begin
      t = 0;
      while (sb.size() > 0 && t < 2000) begin
        t++;
        @(posedge Clk);
      end
      if (sb.size() > 0) begin
        cmp("drain_timeout", sb.size(), 0);
        sb.delete();
      end
      #1;
    end
  endtask
  initial forever begin
    @(posedge Clk);
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 :
                (ready_mode == 1) ? ($time / 10) % 3 == 0 : 1'($urandom_range(1));
  end
  initial forever begin
    @(negedge Clk);
    if (Reset) begin
      run = 0;
      continue;
    end
    if (busy) begin
      run++;
      if (chk_eq) cmp("cmp_eq", dut.u_cmp.eq, 1);
    end
    if (out_valid) begin
      if (sb.size() == 0) cmp("unexpected_output", out_valid, 0);
      else begin
        cmp("out_data", out_data, sb[0].d);
        if (out_ready) begin
          cmp("done", done, sb[0].last);
          cmp("swap_cnt", swap_cnt, sb[0].swaps);
          if (sb[0].first) cmp("sort_cycles", run, sb[0].cycles);
          if (sb[0].last) run = 0;
          void'(sb.pop_front());
        end else cmp("done_stall", done, 0);
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] f [N];
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    cmp("rst_in_ready", in_ready, 1);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_out_data", out_data, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_swap_cnt", swap_cnt, 0);
    cmp("rst_done", done, 0);
    @(posedge Clk);
    #1;
    Reset = 0;
    f = '{0, 1, 2, 3, 4, 5, 6, 7};
    frame(f, -1, 1);
    f = '{7, 6, 5, 4, 3, 2, 1, 0};
    frame(f, -1, 1);
    chk_eq = 1;
    f = '{5, 5, 5, 5, 5, 5, 5, 5};
    frame(f, -1, 1);
    chk_eq = 0;
    ready_mode = 1;
    f = '{9, 3, 9, 0, 15, 3, 1, 0};
    frame(f, -1, 1);
    ready_mode = 0;
    f = '{7, 6, 5, 4, 3, 2, 1, 0};
    frame(f, -1, 0);
    repeat (9) @(posedge Clk);
    #1;
    cmp("pre_reset_busy", busy, 1);
    Reset = 1;
    @(posedge Clk);
    #1;
    Reset = 0;
    cmp("midsort_rst_busy", busy, 0);
    cmp("midsort_rst_in_ready", in_ready, 1);
    cmp("midsort_rst_swap_cnt", swap_cnt, 0);
    cmp("midsort_rst_out_valid", out_valid, 0);
    f = '{2, 1, 4, 3, 6, 5, 0, 7};
    frame(f, -1, 1);
    f = '{4, 12, 1, 8, 8, 2, 14, 3};
    frame(f, 3, 1);
    ready_mode = 2;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) f[i] = 4'($urandom_range(15));
      frame(f, (r % 5 == 0) ? int'($urandom_range(N - 2)) : -1, 1);
    end
    ready_mode = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
